mul_div: RTL and testbench

MUL_DIV -- requirements
Module: mul_div

---
 rtl/mul_div.sv | 125 ++++++++++++
 tb/tb_mul_div.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mul_div.sv
// mul_div: single-cycle RV32M multiply/divide unit.
// All arithmetic is combinational from the operands and operation code; the
// selected value is captured into the result register on every rising clock
// edge, so a new operation can be issued each cycle with one cycle of latency.
module mul_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    input  logic [4:0]  execute_type,
    output logic [31:0] result
);

    localparam logic [4:0] OP_MUL    = 5'd16;
    localparam logic [4:0] OP_MULH   = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_MULHU  = 5'd19;
    localparam logic [4:0] OP_DIV    = 5'd20;
    localparam logic [4:0] OP_DIVU   = 5'd21;
    localparam logic [4:0] OP_REM    = 5'd22;
    localparam logic [4:0] OP_REMU   = 5'd23;

    // Unsigned restoring divider, fully unrolled. Returns {quotient, remainder}.
    // A zero divisor naturally yields an all-ones quotient and remainder equal
    // to the numerator, but callers still special-case it for clarity.
    function automatic logic [63:0] udiv(input logic [31:0] num, input logic [31:0] den);
        logic [32:0] part;
        logic [31:0] quo;
        part = '0;
        quo  = '0;
        for (int i = 31; i >= 0; i--) begin
            part = {part[31:0], num[i]};
            if (part >= {1'b0, den}) begin
                part   = part - {1'b0, den};
                quo[i] = 1'b1;
            end
        end
        return {quo, part[31:0]};
    endfunction

    // Two's-complement negation helper used for magnitude conversion and sign restore.
    function automatic logic [31:0] negate(input logic [31:0] val);
        return ~val + 32'd1;
    endfunction

    logic               mul_a_signed;
    logic               mul_b_signed;
    logic signed [32:0] mul_a;
    logic signed [32:0] mul_b;
    logic signed [65:0] product;

    logic               div_signed;
    logic               dividend_neg;
    logic               divisor_neg;
    logic [31:0]        dividend_mag;
    logic [31:0]        divisor_mag;
    logic [63:0]        div_out;
    logic [31:0]        quot_mag;
    logic [31:0]        rem_mag;
    logic [31:0]        quotient;
    logic [31:0]        remainder;
    logic               divide_by_zero;
    logic               signed_overflow;

    logic [31:0]        result_next;

    // Multiplier: operands extended to 33 bits so one signed multiply covers
    // signed x signed, signed x unsigned and unsigned x unsigned with the full
    // 64-bit product preserved.
    always_comb begin
        mul_a_signed = (execute_type == OP_MULH) || (execute_type == OP_MULHSU);
        mul_b_signed = (execute_type == OP_MULH);
        mul_a        = {mul_a_signed & operand1[31], operand1};
        mul_b        = {mul_b_signed & operand2[31], operand2};
        product      = mul_a * mul_b;
    end

    // Divider: signed forms divide magnitudes, then restore the quotient sign
    // from the operand signs and the remainder sign from the dividend.
    always_comb begin
        div_signed      = (execute_type == OP_DIV) || (execute_type == OP_REM);
        dividend_neg    = div_signed & operand1[31];
        divisor_neg     = div_signed & operand2[31];
        dividend_mag    = dividend_neg ? negate(operand1) : operand1;
        divisor_mag     = divisor_neg  ? negate(operand2) : operand2;
        div_out         = udiv(dividend_mag, divisor_mag);
        quot_mag        = div_out[63:32];
        rem_mag         = div_out[31:0];
        quotient        = (dividend_neg ^ divisor_neg) ? negate(quot_mag) : quot_mag;
        remainder       = dividend_neg ? negate(rem_mag) : rem_mag;
        divide_by_zero  = (operand2 == 32'd0);
        signed_overflow = (operand1 == 32'h8000_0000) && (operand2 == 32'hFFFF_FFFF);
    end

    // Operation select, including the architecturally defined corner cases.
    always_comb begin
        result_next = 32'h0000_0000;
        case (execute_type)
            OP_MUL:    result_next = product[31:0];
            OP_MULH:   result_next = product[63:32];
            OP_MULHSU: result_next = product[63:32];
            OP_MULHU:  result_next = product[63:32];
            OP_DIV: begin
                if (divide_by_zero)       result_next = 32'hFFFF_FFFF;
                else if (signed_overflow) result_next = 32'h8000_0000;
                else                      result_next = quotient;
            end
            OP_DIVU:   result_next = divide_by_zero ? 32'hFFFF_FFFF : quotient;
            OP_REM: begin
                if (divide_by_zero)       result_next = operand1;
                else if (signed_overflow) result_next = 32'h0000_0000;
                else                      result_next = remainder;
            end
            OP_REMU:   result_next = divide_by_zero ? operand1 : remainder;
            default:   result_next = 32'h0000_0000;
        endcase
    end

    // Result register: cleared asynchronously, otherwise loads every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) result <= 32'h0000_0000;
        else        result <= result_next;
    end

endmodule

// File: tb/tb_mul_div.sv
// tb_mul_div: directed and randomized checks of mul_div against a plain
// 64-bit arithmetic reference model.
module tb_mul_div;

    logic        clk;
    logic        rst_n;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [4:0]  execute_type;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q;
    bit          exp_vld;
    string       exp_tag;

    mul_div dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .operand1     (operand1),
        .operand2     (operand2),
        .execute_type (execute_type),
        .result       (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model straight from the instruction definitions using 64-bit math.
    function automatic logic [31:0] ref_model(input logic [4:0] t, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = 32'h0;
        case (t)
            5'd16: begin p = sa * sb; r = p[31:0]; end
            5'd17: begin p = sa * sb; r = p[63:32]; end
            5'd18: begin p = sa * longint'({32'h0, b}); r = p[63:32]; end
            5'd19: begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
            5'd20: begin
                if (b == 32'h0) r = 32'hFFFF_FFFF;
                else begin p = sa / sb; r = p[31:0]; end
            end
            5'd21: r = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            5'd22: begin
                if (b == 32'h0) r = a;
                else begin p = sa % sb; r = p[31:0]; end
            end
            5'd23: r = (b == 32'h0) ? a : a % b;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    // Issue one operation on a falling edge; the previous operation's result,
    // registered at the intervening rising edge, is checked at the same time.
    task automatic step(input string tag, input logic [4:0] t, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
        @(negedge clk);
        if (exp_vld) check(exp_tag, result, exp_q);
        execute_type = t;
        operand1     = a;
        operand2     = b;
        exp_q        = exp;
        exp_tag      = tag;
        exp_vld      = 1'b1;
    endtask

    task automatic flush();
        @(negedge clk);
        if (exp_vld) check(exp_tag, result, exp_q);
        exp_vld = 1'b0;
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'h0000_0000;
            1:       v = 32'h8000_0000;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'h0000_0001;
            4:       v = $urandom_range(0, 255);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        logic [4:0]  t;
        logic [31:0] a;
        logic [31:0] b;

        exp_vld      = 1'b0;
        exp_q        = 32'h0;
        exp_tag      = "";
        operand1     = 32'd3;
        operand2     = 32'd4;
        execute_type = 5'd16;
        rst_n        = 1'b1;
        #1 rst_n     = 1'b0;
        #2 check("reset_async", result, 32'h0);
        @(posedge clk);
        #1 check("reset_hold", result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, issued back-to-back.
        step("mul_7_m3",      5'd16, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
        step("mulh_min_min",  5'd17, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
        step("mulhu_max",     5'd19, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
        step("mulhsu_max",    5'd18, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step("div_m7_2",      5'd20, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
        step("rem_m7_2",      5'd22, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
        step("divu_m7_2",     5'd21, 32'hFFFF_FFF9,  32'd2,         32'h7FFF_FFFC);
        step("remu_m7_2",     5'd23, 32'hFFFF_FFF9,  32'd2,         32'h0000_0001);
        step("div_by0",       5'd20, 32'h1234_5678,  32'd0,         32'hFFFF_FFFF);
        step("divu_by0",      5'd21, 32'h1234_5678,  32'd0,         32'hFFFF_FFFF);
        step("rem_by0",       5'd22, 32'h1234_5678,  32'd0,         32'h1234_5678);
        step("remu_by0",      5'd23, 32'h1234_5678,  32'd0,         32'h1234_5678);
        step("div_ovf",       5'd20, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
        step("rem_ovf",       5'd22, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000);
        step("undef_0",       5'd0,  32'd5,          32'd6,         32'h0);
        step("undef_15",      5'd15, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0);
        step("undef_31",      5'd31, 32'd100,        32'd7,         32'h0);
        step("b2b_mul",       5'd16, 32'd1000,       32'd1000,      32'd1000000);
        step("b2b_divu",      5'd21, 32'd1000000,    32'd7,         32'd142857);
        step("rem_neg_neg",   5'd22, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'hFFFF_FFFF);
        step("div_pos_neg",   5'd20, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD);

        // Randomized operations, mostly valid codes with boundary-biased operands.
        for (int n = 0; n < 400; n++) begin
            t = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31))
                                            : 5'($urandom_range(16, 23));
            a = pick_operand();
            b = pick_operand();
            step("random", t, a, b, ref_model(t, a, b));
        end
        flush();

        // Reset asserted mid-stream clears the register without a clock edge
        // and discards the pending value.
        step("pre_rst", 5'd16, 32'd5, 32'd6, 32'd30);
        step("pre_rst2", 5'd16, 32'd9, 32'd9, 32'd81);
        exp_vld = 1'b0;
        @(posedge clk);
        #2 check("pre_rst_load", result, 32'd81);
        rst_n = 1'b0;
        #1 check("rst_midstream", result, 32'h0);
        @(posedge clk);
        #1 check("rst_held", result, 32'h0);
        @(negedge clk);
        execute_type = 5'd21;
        operand1     = 32'd100;
        operand2     = 32'd7;
        rst_n        = 1'b1;
        @(negedge clk);
        check("rst_first_edge", result, 32'd14);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against any unexpected stall of the stimulus.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
